// File: rtl/vga_timing_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_decoder
// Brief    : Measures incoming hsync/vsync timing, declares lock and recovers
//            visible line/column. Define VGA_DEC_ERRCNT_EN to build err_count.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_decoder #(
  parameter int CLK_PER_PIX     = 4,
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int H_ACTIVE        = 640,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int V_ACTIVE        = 480,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int H_TOL           = 2,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic        locked,
  output logic        lock_lost,
  output logic [15:0] h_period,
  output logic [11:0] v_lines,
  output logic [11:0] line,
  output logic [11:0] column,
  output logic        pixel_valid,
  output logic [15:0] err_count
);

  localparam int PRE_W = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_PIX - 1);
  localparam logic [15:0] H_NOM_C   = 16'(H_TOTAL * CLK_PER_PIX);
  localparam logic [15:0] H_TOL_C   = 16'(H_TOL);
  localparam logic [15:0] TIMEOUT_C = 16'(2 * H_TOTAL * CLK_PER_PIX);
  localparam logic [11:0] V_TOTAL_C = 12'(V_TOTAL);
  localparam logic [11:0] H_START_C = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_END_C   = 12'(H_SYNC + H_BACK + H_ACTIVE);
  // Edge count of the first visible line: the line starting at vsync counts as 1.
  localparam logic [11:0] V_START_C = 12'(V_SYNC + V_BACK + 1);
  localparam logic [11:0] V_END_C   = 12'(V_SYNC + V_BACK + 1 + V_ACTIVE);
  localparam logic [7:0]  LOCK_C    = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  logic [2:0]       hs_sync_q, vs_sync_q;
  logic             hs_edge_q, vs_edge_q;
  logic             hs_lead, vs_lead;
  logic [15:0]      h_cnt_q, h_cnt_d, h_period_q, h_period_d, h_diff;
  logic             h_seen_q, h_seen_d;
  logic             frame_bad_q, frame_bad_d;
  logic [11:0]      v_cnt_q, v_cnt_d, v_lines_q, v_lines_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [11:0]      pix_q, pix_d;
  state_t           state_q, state_d;
  logic [7:0]       good_q, good_d;
  logic             locked_q, locked_d, lock_lost_q, lock_lost_d;
  logic             line_bad, frame_good, timeout, pix_in, row_in;

  assign hs_lead = (SYNC_ACTIVE_LOW != 0) ? (~hs_sync_q[1] & hs_sync_q[2])
                                          : (hs_sync_q[1] & ~hs_sync_q[2]);
  assign vs_lead = (SYNC_ACTIVE_LOW != 0) ? (~vs_sync_q[1] & vs_sync_q[2])
                                          : (vs_sync_q[1] & ~vs_sync_q[2]);

  // The first hsync edge after reset/timeout has no valid reference, so skip its check.
  assign h_diff     = (h_cnt_q > H_NOM_C) ? (h_cnt_q - H_NOM_C) : (H_NOM_C - h_cnt_q);
  assign line_bad   = hs_edge_q && h_seen_q && (h_diff > H_TOL_C);
  assign frame_good = (v_cnt_q == V_TOTAL_C) && !frame_bad_q;
  assign timeout    = !hs_edge_q && (h_cnt_q == TIMEOUT_C);

  always_comb begin
    h_cnt_d     = h_cnt_q;
    h_period_d  = h_period_q;
    h_seen_d    = h_seen_q;
    frame_bad_d = frame_bad_q;
    v_cnt_d     = v_cnt_q;
    v_lines_d   = v_lines_q;
    pre_d       = pre_q;
    pix_d       = pix_q;
    state_d     = state_q;
    good_d      = good_q;

    if (hs_edge_q) begin
      h_cnt_d    = 16'd1;
      h_period_d = h_cnt_q;
      h_seen_d   = 1'b1;
      pre_d      = '0;
      pix_d      = '0;
    end else begin
      if (h_cnt_q != 16'hFFFF) h_cnt_d = h_cnt_q + 16'd1;
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (pix_q != 12'hFFF) pix_d = pix_q + 12'd1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    // A coincident hsync edge belongs to the frame that starts at this vsync.
    if (vs_edge_q) begin
      v_lines_d   = v_cnt_q;
      v_cnt_d     = hs_edge_q ? 12'd1 : 12'd0;
      frame_bad_d = line_bad;
    end else begin
      if (hs_edge_q && v_cnt_q != 12'hFFF) v_cnt_d = v_cnt_q + 12'd1;
      if (line_bad) frame_bad_d = 1'b1;
    end

    case (state_q)
      S_SEARCH: begin
        if (vs_edge_q) begin
          state_d = S_MEASURE;
          good_d  = 8'd0;
        end
      end
      S_MEASURE: begin
        if (vs_edge_q) begin
          if (frame_good) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 >= LOCK_C) state_d = S_LOCKED;
          end else begin
            good_d = 8'd0;
          end
        end
      end
      S_LOCKED: begin
        if (vs_edge_q && !frame_good) begin
          state_d = S_MEASURE;
          good_d  = 8'd0;
        end
      end
      default: state_d = S_SEARCH;
    endcase

    if (timeout) begin
      state_d  = S_SEARCH;
      good_d   = 8'd0;
      h_seen_d = 1'b0;
    end

    locked_d    = (state_d == S_LOCKED);
    lock_lost_d = (state_q == S_LOCKED) && (state_d != S_LOCKED);
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      hs_sync_q   <= '0;
      vs_sync_q   <= '0;
      hs_edge_q   <= 1'b0;
      vs_edge_q   <= 1'b0;
      h_cnt_q     <= '0;
      h_period_q  <= '0;
      h_seen_q    <= 1'b0;
      frame_bad_q <= 1'b0;
      v_cnt_q     <= '0;
      v_lines_q   <= '0;
      pre_q       <= '0;
      pix_q       <= '0;
      state_q     <= S_SEARCH;
      good_q      <= '0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      hs_sync_q   <= {hs_sync_q[1:0], hsync};
      vs_sync_q   <= {vs_sync_q[1:0], vsync};
      hs_edge_q   <= hs_lead;
      vs_edge_q   <= vs_lead;
      h_cnt_q     <= h_cnt_d;
      h_period_q  <= h_period_d;
      h_seen_q    <= h_seen_d;
      frame_bad_q <= frame_bad_d;
      v_cnt_q     <= v_cnt_d;
      v_lines_q   <= v_lines_d;
      pre_q       <= pre_d;
      pix_q       <= pix_d;
      state_q     <= state_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    pix_in      = (pix_q >= H_START_C) && (pix_q < H_END_C);
    row_in      = (v_cnt_q >= V_START_C) && (v_cnt_q < V_END_C);
    pixel_valid = locked_q && pix_in && row_in;
    column      = pixel_valid ? (pix_q - H_START_C) : 12'd0;
    line        = pixel_valid ? (v_cnt_q - V_START_C) : 12'd0;
  end

  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;
  assign h_period  = h_period_q;
  assign v_lines   = v_lines_q;

`ifdef VGA_DEC_ERRCNT_EN
  logic [15:0] err_q;
  logic        eval_bad;

  assign eval_bad = vs_edge_q && !frame_good && (state_q != S_SEARCH);

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if ((eval_bad || timeout) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_decoder
// Brief    : Directed bench for vga_timing_decoder on a reduced video mode,
//            with a second instance fed inverted syncs (active-high polarity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_decoder;

  localparam int CPP = 4;
  localparam int H_T = 40;
  localparam int H_S = 4;
  localparam int H_B = 4;
  localparam int H_A = 24;
  localparam int V_T = 20;
  localparam int V_S = 2;
  localparam int V_B = 3;
  localparam int V_A = 12;
  localparam int WAIT_LIMIT = 20000;

  logic        clk100 = 1'b0;
  logic        reset  = 1'b1;
  logic        hsync  = 1'b1;
  logic        vsync  = 1'b1;
  logic        hsync_n, vsync_n;

  logic        locked, lock_lost, pixel_valid;
  logic [15:0] h_period, err_count;
  logic [11:0] v_lines, line, column;

  logic        locked2, lock_lost2, pixel_valid2;
  logic [15:0] h_period2, err_count2;
  logic [11:0] v_lines2, line2, column2;

  assign hsync_n = ~hsync;
  assign vsync_n = ~vsync;

  always #5 clk100 = ~clk100;

  vga_timing_decoder #(
    .CLK_PER_PIX(CPP), .H_TOTAL(H_T), .H_SYNC(H_S), .H_BACK(H_B), .H_ACTIVE(H_A),
    .V_TOTAL(V_T), .V_SYNC(V_S), .V_BACK(V_B), .V_ACTIVE(V_A),
    .SYNC_ACTIVE_LOW(1), .H_TOL(2), .LOCK_FRAMES(2)
  ) u_dut (
    .clk100(clk100), .reset(reset), .hsync(hsync), .vsync(vsync),
    .locked(locked), .lock_lost(lock_lost), .h_period(h_period), .v_lines(v_lines),
    .line(line), .column(column), .pixel_valid(pixel_valid), .err_count(err_count)
  );

  vga_timing_decoder #(
    .CLK_PER_PIX(CPP), .H_TOTAL(H_T), .H_SYNC(H_S), .H_BACK(H_B), .H_ACTIVE(H_A),
    .V_TOTAL(V_T), .V_SYNC(V_S), .V_BACK(V_B), .V_ACTIVE(V_A),
    .SYNC_ACTIVE_LOW(0), .H_TOL(2), .LOCK_FRAMES(2)
  ) u_dut_pos (
    .clk100(clk100), .reset(reset), .hsync(hsync_n), .vsync(vsync_n),
    .locked(locked2), .lock_lost(lock_lost2), .h_period(h_period2), .v_lines(v_lines2),
    .line(line2), .column(column2), .pixel_valid(pixel_valid2), .err_count(err_count2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ll_cnt   = 0;

  int line_per  = H_T * CPP;
  int bad_frame = -1;
  bit hold_h    = 1'b0;
  bit gen_en    = 1'b0;
  int g_frame   = -1;
  int g_ln      = 0;
  int g_c       = 0;

`ifdef VGA_DEC_ERRCNT_EN
  localparam int ERR_ONE = 1;
`else
  localparam int ERR_ONE = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Returns 2 time units after the posedge that follows generator cycle (f, ln, c).
  task automatic wait_pos(input int f, input int ln, input int c);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < WAIT_LIMIT) begin
      @(posedge clk100);
      n++;
      hit = (g_frame == f) && (g_ln == ln) && (g_c == c);
    end
    #2;
    check("pos_reached", {31'd0, hit}, 32'd1);
  endtask

  always @(negedge clk100) if (lock_lost) ll_cnt++;

  // Sync generator: vsync asserts with the hsync pulse at the start of line 0.
  initial begin
    wait (gen_en);
    for (int f = 0; f < 64; f++) begin
      for (int ln = 0; ln < V_T; ln++) begin
        int per;
        per = line_per + (((f == bad_frame) && (ln == 7)) ? 3 : 0);
        for (int c = 0; c < per; c++) begin
          @(negedge clk100);
          g_frame = f;
          g_ln    = ln;
          g_c     = c;
          hsync   = (!hold_h && (c < H_S * CPP)) ? 1'b0 : 1'b1;
          vsync   = (ln < V_S) ? 1'b0 : 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk100);
    #2;
    check("rst_locked",      {31'd0, locked},      32'd0);
    check("rst_lock_lost",   {31'd0, lock_lost},   32'd0);
    check("rst_h_period",    {16'd0, h_period},    32'd0);
    check("rst_v_lines",     {20'd0, v_lines},     32'd0);
    check("rst_line",        {20'd0, line},        32'd0);
    check("rst_column",      {20'd0, column},      32'd0);
    check("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    check("rst_err_count",   {16'd0, err_count},   32'd0);
    @(negedge clk100);
    reset  = 1'b0;
    gen_en = 1'b1;

    // Lock on third vsync edge
    wait_pos(1, 0, 10);
    check("locked_f1", {31'd0, locked}, 32'd0);
    wait_pos(2, 0, 10);
    check("locked_f2",     {31'd0, locked},   32'd1);
    check("h_period_f2",   {16'd0, h_period}, 32'd160);
    check("v_lines_f2",    {20'd0, v_lines},  32'd20);
    check("err_f2",        {16'd0, err_count}, 32'd0);
    check("pos_locked_f2", {31'd0, locked2},  32'd1);
    check("pos_h_period",  {16'd0, h_period2}, 32'd160);

    // Visible-area boundaries
    wait_pos(2, 4, 36);
    check("row4_valid", {31'd0, pixel_valid}, 32'd0);
    check("row4_line",  {20'd0, line},        32'd0);
    wait_pos(2, 5, 32);
    check("pix7_valid",  {31'd0, pixel_valid}, 32'd0);
    check("pix7_column", {20'd0, column},      32'd0);
    wait_pos(2, 5, 36);
    check("first_valid",  {31'd0, pixel_valid}, 32'd1);
    check("first_column", {20'd0, column},      32'd0);
    check("first_line",   {20'd0, line},        32'd0);
    check("pos_first_valid", {31'd0, pixel_valid2}, 32'd1);
    wait_pos(2, 10, 128);
    check("last_col_valid", {31'd0, pixel_valid}, 32'd1);
    check("last_column",    {20'd0, column},      32'd23);
    check("mid_line",       {20'd0, line},        32'd5);
    check("pos_last_column", {20'd0, column2},    32'd23);
    wait_pos(2, 10, 132);
    check("past_col_valid",  {31'd0, pixel_valid}, 32'd0);
    check("past_col_column", {20'd0, column},      32'd0);
    wait_pos(2, 16, 36);
    check("last_row_valid", {31'd0, pixel_valid}, 32'd1);
    check("last_row_line",  {20'd0, line},        32'd11);
    wait_pos(2, 17, 36);
    check("past_row_valid", {31'd0, pixel_valid}, 32'd0);

    // One 163-cycle line in frame 3
    bad_frame = 3;
    wait_pos(3, 0, 10);
    check("locked_f3", {31'd0, locked}, 32'd1);
    wait_pos(4, 0, 10);
    check("locked_after_bad", {31'd0, locked},    32'd0);
    check("lock_lost_pulses", ll_cnt,             32'd1);
    check("err_after_bad",    {16'd0, err_count}, ERR_ONE);
    check("v_lines_f4",       {20'd0, v_lines},   32'd20);
    check("pos_locked_bad",   {31'd0, locked2},   32'd0);
    wait_pos(5, 0, 10);
    check("locked_f5", {31'd0, locked}, 32'd0);
    wait_pos(6, 0, 10);
    check("relock_f6", {31'd0, locked}, 32'd1);

    // Line period 162, inside tolerance
    line_per = H_T * CPP + 2;
    wait_pos(7, 0, 10);
    check("locked_tol",   {31'd0, locked},   32'd1);
    check("h_period_tol", {16'd0, h_period}, 32'd162);

    // Mid-frame reset while locked
    wait_pos(8, 8, 40);
    check("pre_rst_valid",  {31'd0, pixel_valid}, 32'd1);
    check("pre_rst_column", {20'd0, column},      32'd1);
    check("pre_rst_line",   {20'd0, line},        32'd3);
    reset = 1'b1;
    #1;
    check("mrst_locked",      {31'd0, locked},      32'd0);
    check("mrst_lock_lost",   {31'd0, lock_lost},   32'd0);
    check("mrst_h_period",    {16'd0, h_period},    32'd0);
    check("mrst_v_lines",     {20'd0, v_lines},     32'd0);
    check("mrst_line",        {20'd0, line},        32'd0);
    check("mrst_column",      {20'd0, column},      32'd0);
    check("mrst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    check("mrst_err_count",   {16'd0, err_count},   32'd0);
    @(negedge clk100);
    reset = 1'b0;
    wait_pos(10, 0, 10);
    check("locked_rst_f10", {31'd0, locked}, 32'd0);
    wait_pos(11, 0, 10);
    check("locked_rst_f11",   {31'd0, locked},   32'd1);
    check("h_period_rst",     {16'd0, h_period}, 32'd162);
    check("v_lines_rst",      {20'd0, v_lines},  32'd20);
    check("pos_locked_rst",   {31'd0, locked2},  32'd1);
    check("pos_h_period_rst", {16'd0, h_period2}, 32'd162);

    // hsync stuck inactive while locked
    wait_pos(11, 3, 10);
    hold_h = 1'b1;
    repeat (600) @(posedge clk100);
    #2;
    check("tmo_locked",     {31'd0, locked},    32'd0);
    check("tmo_lock_lost",  ll_cnt,             32'd2);
    check("tmo_err",        {16'd0, err_count}, ERR_ONE);
    check("pos_tmo_locked", {31'd0, locked2},   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
